// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter.
// master: the requester side (drives requests, takes responses).
// slave : the arbiter side.
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [3:0]  req0_ctrl;

   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  req1_ctrl;

   logic        rsp0_valid;
   logic        rsp0_ready;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctrl,
      output req1_valid, req1_a, req1_b, req1_ctrl,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctrl,
      input  req1_valid, req1_a, req1_b, req1_ctrl,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: time-shares one combinational ALU between two requesters.
// Round-robin grant, one operation in flight, registered ALU operands and
// registered result/flags returned over a valid/ready response.
// Optional feature: define ALU_ARB_PERF_EN to add perf_grant0/perf_grant1/
// perf_busy saturating counters.
module alu_arbiter #(
   parameter int unsigned RESET_PRIORITY = 0,
   parameter logic [3:0]  CTRL_MAX       = 4'd11
) (
   input  logic                clk,
   input  logic                rst,
   alu_arbiter_if.slave        bus,
   output logic [31:0]         alu_src_a,
   output logic [31:0]         alu_src_b,
   output logic [3:0]          alu_control,
   input  logic [31:0]         alu_result,
   input  logic                alu_zero,
   input  logic                alu_carry,
   input  logic                alu_overflow,
   input  logic                alu_negative
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [15:0]         perf_grant0,
   output logic [15:0]         perf_grant1,
   output logic [15:0]         perf_busy
`endif
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   // last_q = 1 means requester 1 won the previous grant, so requester 0 wins a tie
   localparam logic LastReset = (RESET_PRIORITY == 0) ? 1'b1 : 1'b0;

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic        grant0, grant1;
   logic [31:0] sel_a, sel_b;
   logic [3:0]  sel_ctrl;
   logic        alu_load;
   logic        rsp_load_alu;
   logic        rsp_load_err;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] alu_src_a_q, alu_src_b_q;
   logic [3:0]  alu_control_q;
   logic [31:0] rsp_result_q;
   logic [3:0]  rsp_flags_q;
   logic        rsp_err_q;

   // Round-robin grant and selection of the winning request
   always_comb begin
      grant0   = bus.req0_valid & (~bus.req1_valid | last_q);
      grant1   = bus.req1_valid & (~bus.req0_valid | ~last_q);
      sel_a    = grant1 ? bus.req1_a    : bus.req0_a;
      sel_b    = grant1 ? bus.req1_b    : bus.req0_b;
      sel_ctrl = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
   end

   // Next-state, handshake outputs and register load strobes
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      owner_d      = owner_q;
      alu_load     = 1'b0;
      rsp_load_alu = 1'b0;
      rsp_load_err = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Ready is masked while reset is held so nothing looks accepted.
            req0_ready = grant0 & ~rst;
            req1_ready = grant1 & ~rst;
            if (grant0 | grant1) begin
               owner_d = grant1;
               last_d  = grant1;
               if (sel_ctrl <= CTRL_MAX) begin
                  alu_load = 1'b1;
                  state_d  = StExec;
               end else begin
                  rsp_load_err = 1'b1;
                  state_d      = StResp;
               end
            end
         end
         StExec: begin
            rsp_load_alu = 1'b1;
            state_d      = StResp;
         end
         StResp: begin
            rsp0_valid = ~owner_q;
            rsp1_valid = owner_q;
            if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM, grant pointer and owner registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         last_q  <= LastReset;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

   // ALU operand registers; held outside an accepted legal operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_src_a_q   <= '0;
         alu_src_b_q   <= '0;
         alu_control_q <= '0;
      end else if (alu_load) begin
         alu_src_a_q   <= sel_a;
         alu_src_b_q   <= sel_b;
         alu_control_q <= sel_ctrl;
      end
   end

   // Response registers: ALU capture after EXEC, or error response on reject
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else if (rsp_load_alu) begin
         rsp_result_q <= alu_result;
         rsp_flags_q  <= {alu_negative, alu_overflow, alu_carry, alu_zero};
         rsp_err_q    <= 1'b0;
      end else if (rsp_load_err) begin
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b1;
      end
   end

   assign bus.req0_ready = req0_ready;
   assign bus.req1_ready = req1_ready;
   assign bus.rsp0_valid = rsp0_valid;
   assign bus.rsp1_valid = rsp1_valid;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;
   assign alu_src_a      = alu_src_a_q;
   assign alu_src_b      = alu_src_b_q;
   assign alu_control    = alu_control_q;

`ifdef ALU_ARB_PERF_EN
   logic [15:0] perf_grant0_q, perf_grant1_q, perf_busy_q;

   // Saturating accept counters (illegal ops included) and busy-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_grant0_q <= '0;
         perf_grant1_q <= '0;
         perf_busy_q   <= '0;
      end else begin
         if (req0_ready && bus.req0_valid && perf_grant0_q != 16'hFFFF) begin
            perf_grant0_q <= perf_grant0_q + 16'd1;
         end
         if (req1_ready && bus.req1_valid && perf_grant1_q != 16'hFFFF) begin
            perf_grant1_q <= perf_grant1_q + 16'd1;
         end
         if (state_q != StIdle && perf_busy_q != 16'hFFFF) begin
            perf_busy_q <= perf_busy_q + 16'd1;
         end
      end
   end

   assign perf_grant0 = perf_grant0_q;
   assign perf_grant1 = perf_grant1_q;
   assign perf_busy   = perf_busy_q;
`endif

endmodule
